// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared types and constants for the NAND CPU fetch stage
package nand_cpu_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } FETCH_STATE;

    localparam int FETCH_DEPTH = 2;
    localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decoder handshake bundle for fetch_unit
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            imem_req_val;
    logic            imem_req_rdy;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rsp_val;
    logic [7:0]      imem_rsp_data;
    logic            dec_valid;
    logic [7:0]      dec_instr;
    logic [PC_W-1:0] dec_pc;
    logic            dec_ready;

    modport master (
        output imem_req_val, imem_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_rdy, imem_rsp_val, imem_rsp_data, dec_ready
    );

    modport slave (
        input  imem_req_val, imem_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_rdy, imem_rsp_val, imem_rsp_data, dec_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry FIFO of {instr, pc} between fetch and decode
module fetch_buffer
    import nand_cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_instr,
    input  logic [PC_W-1:0]        push_pc,
    input  logic                   pop,
    input  logic                   flush,
    output logic [FETCH_CNT_W-1:0] count,
    output logic [7:0]             head_instr,
    output logic [PC_W-1:0]        head_pc
);

    logic [7:0]             instr_q [FETCH_DEPTH];
    logic [PC_W-1:0]        pc_q    [FETCH_DEPTH];
    logic [FETCH_CNT_W-1:0] count_q;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    instr_q[count_q[0]] <= push_instr;
                    pc_q[count_q[0]]    <= push_pc;
                    count_q             <= count_q + 1'b1;
                end
                2'b01: begin
                    instr_q[0] <= instr_q[1];
                    pc_q[0]    <= pc_q[1];
                    count_q    <= count_q - 1'b1;
                end
                2'b11: begin
                    if (count_q == FETCH_CNT_W'(1)) begin
                        instr_q[0] <= push_instr;
                        pc_q[0]    <= push_pc;
                    end else begin
                        instr_q[0] <= instr_q[1];
                        pc_q[0]    <= pc_q[1];
                        instr_q[1] <= push_instr;
                        pc_q[1]    <= push_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = count_q;
    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - NAND CPU fetch stage: PC, single-outstanding imem reads, redirect and halt
module fetch_unit
    import nand_cpu_pkg::*;
#(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
    parameter logic [PC_W-1:0] INT_VECTOR = 8'hF0
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    bus,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            int_req,
    output logic [PC_W-1:0] epc,
    input  logic            halt,
    output logic            halted
);

    FETCH_STATE      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            pending_q, pending_d;
    logic            drop_q, drop_d;

    logic                   req_val;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic                   dec_valid;
    logic                   credit_ok;
    logic [FETCH_CNT_W-1:0] count;
    logic [7:0]             head_instr;
    logic [PC_W-1:0]        head_pc;

    fetch_buffer #(.PC_W(PC_W)) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_instr (bus.imem_rsp_data),
        .push_pc    (pc_q - 1'b1),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    assign dec_valid = (count != '0);
    assign pop       = dec_valid & bus.dec_ready;
    assign credit_ok = (32'(count) + 32'(pending_q)) < FETCH_DEPTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        req_val   = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;

        if (bus.imem_rsp_val) begin
            pending_d = 1'b0;
            drop_d    = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (redirect) begin
                    flush  = 1'b1;
                    pc_d   = int_req ? INT_VECTOR : redirect_pc;
                    // A response landing this same cycle is simply not pushed.
                    drop_d = pending_q & ~bus.imem_rsp_val;
                    if (int_req) begin
                        epc_d = dec_valid ? head_pc : pc_q;
                    end
                end
                if (halt) begin
                    state_d = HALTED;
                    flush   = 1'b1;
                end
                if (!redirect && !halt) begin
                    req_val = !pending_q && credit_ok;
                    if (req_val && bus.imem_req_rdy) begin
                        pending_d = 1'b1;
                        pc_d      = pc_q + 1'b1;
                    end
                    push = bus.imem_rsp_val & ~drop_q;
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase
    end

    assign bus.imem_req_val = req_val & ~rst;
    assign bus.imem_addr    = pc_q;
    assign bus.dec_valid    = dec_valid;
    assign bus.dec_instr    = head_instr;
    assign bus.dec_pc       = head_pc;
    assign epc              = epc_q;
    assign halted           = (state_q == HALTED) & ~pending_q;

endmodule
